// File: rtl/sram_tpsram_arbiter.sv
// sram_tpsram_arbiter
//   Shares one two-port SRAM (separate write/read ports, single clock) between
//   masters M0 and M1. Write and read ports are arbitrated independently with a
//   round-robin req/gnt scheme; read data returns one cycle after the grant with
//   a registered valid and owner tag.
//
// Ports
//   CLK, RESET                      clock, asynchronous active-high reset
//   Mn_WREQ/WADDR/WDATA/WBE, Mn_WGNT   write request side (n = 0,1)
//   Mn_RREQ/RADDR, Mn_RGNT           read request side
//   Mn_RVALID, RDATA                 read return (RDATA shared, 0 when idle)
//   W_EN/W_ADDR/W_DATA/WBYTE_EN      SRAM write port
//   R_EN/R_ADDR, R_DATA              SRAM read port (data 1 cycle after R_EN)
//
// Build option
//   ARB_WR_FWD_EN : forward same-cycle write lanes into a colliding read
//                   (write-first). Undefined: SRAM old-data is returned as-is.
module sram_tpsram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 80,
  parameter int BE_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              M0_WREQ,
  input  logic [ADDR_W-1:0] M0_WADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  input  logic [BE_W-1:0]   M0_WBE,
  output logic              M0_WGNT,
  input  logic              M1_WREQ,
  input  logic [ADDR_W-1:0] M1_WADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  input  logic [BE_W-1:0]   M1_WBE,
  output logic              M1_WGNT,
  input  logic              M0_RREQ,
  input  logic [ADDR_W-1:0] M0_RADDR,
  output logic              M0_RGNT,
  input  logic              M1_RREQ,
  input  logic [ADDR_W-1:0] M1_RADDR,
  output logic              M1_RGNT,
  output logic              M0_RVALID,
  output logic              M1_RVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [DATA_W-1:0] W_DATA,
  output logic [BE_W-1:0]   WBYTE_EN,
  output logic              R_EN,
  output logic [ADDR_W-1:0] R_ADDR,
  input  logic [DATA_W-1:0] R_DATA
);

  localparam int LANE_W = DATA_W / BE_W;

  typedef enum logic {MST0 = 1'b0, MST1 = 1'b1} mst_e;

  mst_e wptr_q, wptr_d, wsel_q, wsel_d;
  mst_e rptr_q, rptr_d, rsel_q, rsel_d;
  mst_e rv_own_q;
  logic rv_vld_q;
  logic w_any, r_any;
  logic [DATA_W-1:0] rd_merged;

  // Write arbitration. With no requester the select holds its last winner so
  // the SRAM write address/data stay on that master.
  always_comb begin
    w_any  = M0_WREQ | M1_WREQ;
    wsel_d = wsel_q;
    if (M0_WREQ && M1_WREQ) wsel_d = wptr_q;
    else if (M1_WREQ)       wsel_d = MST1;
    else if (M0_WREQ)       wsel_d = MST0;
    wptr_d = wptr_q;
    if (w_any) wptr_d = (wsel_d == MST0) ? MST1 : MST0;
    W_ADDR   = (wsel_d == MST1) ? M1_WADDR : M0_WADDR;
    W_DATA   = (wsel_d == MST1) ? M1_WDATA : M0_WDATA;
    WBYTE_EN = (wsel_d == MST1) ? M1_WBE   : M0_WBE;
    M0_WGNT  = !RESET && w_any && (wsel_d == MST0);
    M1_WGNT  = !RESET && w_any && (wsel_d == MST1);
    // A grant with no byte enables is consumed without touching the SRAM.
    W_EN     = !RESET && w_any && (WBYTE_EN != '0);
  end

  // Read arbitration, same scheme on its own pointer.
  always_comb begin
    r_any  = M0_RREQ | M1_RREQ;
    rsel_d = rsel_q;
    if (M0_RREQ && M1_RREQ) rsel_d = rptr_q;
    else if (M1_RREQ)       rsel_d = MST1;
    else if (M0_RREQ)       rsel_d = MST0;
    rptr_d = rptr_q;
    if (r_any) rptr_d = (rsel_d == MST0) ? MST1 : MST0;
    R_ADDR  = (rsel_d == MST1) ? M1_RADDR : M0_RADDR;
    M0_RGNT = !RESET && r_any && (rsel_d == MST0);
    M1_RGNT = !RESET && r_any && (rsel_d == MST1);
    R_EN    = !RESET && r_any;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr_q   <= MST0;
      wsel_q   <= MST0;
      rptr_q   <= MST0;
      rsel_q   <= MST0;
      rv_vld_q <= 1'b0;
      rv_own_q <= MST0;
    end else begin
      wptr_q   <= wptr_d;
      wsel_q   <= wsel_d;
      rptr_q   <= rptr_d;
      rsel_q   <= rsel_d;
      rv_vld_q <= r_any;
      rv_own_q <= rsel_d;
    end
  end

`ifdef ARB_WR_FWD_EN
  logic              fwd_hit_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [BE_W-1:0]   fwd_be_q;

  // Capture the write that collides with this cycle's read; its lanes are
  // laid over the (old) SRAM data when the read returns.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_be_q   <= '0;
    end else begin
      fwd_hit_q  <= W_EN && R_EN && (W_ADDR == R_ADDR);
      fwd_data_q <= W_DATA;
      fwd_be_q   <= WBYTE_EN;
    end
  end

  always_comb begin
    rd_merged = R_DATA;
    if (fwd_hit_q) begin
      for (int unsigned k = 0; k < BE_W; k++) begin
        if (fwd_be_q[k]) rd_merged[k*LANE_W +: LANE_W] = fwd_data_q[k*LANE_W +: LANE_W];
      end
    end
  end
`else
  assign rd_merged = R_DATA;
`endif

  always_comb begin
    M0_RVALID = rv_vld_q && (rv_own_q == MST0);
    M1_RVALID = rv_vld_q && (rv_own_q == MST1);
    RDATA     = rv_vld_q ? rd_merged : '0;
  end

endmodule
